// File: rtl/redmule_tb_pkg.sv
// Shared types and constants for the bench-side data-bus demux and address decoder.
// Contents:
//   dest_e        - 3-bit destination code for a decoded bus access
//   MMIO_*        - byte offsets inside the 16-byte MMIO window
//   DEF_*         - default address map
//   is_mem_dest() - true for destinations served by an external TCDM target
package redmule_tb_pkg;

   typedef enum logic [2:0] {
      DestPeri  = 3'd0,
      DestStack = 3'd1,
      DestDmem  = 3'd2,
      DestMmio  = 3'd3,
      DestErr   = 3'd4,
      DestNone  = 3'd7
   } dest_e;

   localparam logic [3:0] MMIO_EXIT   = 4'h0;
   localparam logic [3:0] MMIO_PRINT  = 4'h4;
   localparam logic [3:0] MMIO_CYCLES = 4'h8;
   localparam logic [3:0] MMIO_BAD    = 4'hC;

   localparam logic [31:0] DEF_PERI_ADDR = 32'h0000_1000;
   localparam logic [31:0] DEF_PERI_END  = 32'h0010_0000;
   localparam logic [31:0] DEF_SMEM_ADDR = 32'h0014_0000;
   localparam logic [31:0] DEF_SMEM_SIZE = 32'h0003_0000;
   localparam logic [31:0] DEF_DMEM_ADDR = 32'h0011_0000;
   localparam logic [31:0] DEF_DMEM_SIZE = 32'h0003_0000;
   localparam logic [31:0] DEF_MMIO_ADDR = 32'h8000_0000;

   function automatic logic is_mem_dest(input dest_e d);
      return (d == DestPeri) || (d == DestStack) || (d == DestDmem);
   endfunction

endpackage

// File: rtl/tb_addr_decoder.sv
// Combinational byte-address to destination decode.
// Ports:
//   addr - 32-bit byte address
//   dest - decoded destination; priority peri, stack, dmem, MMIO, otherwise DestErr
module tb_addr_decoder
   import redmule_tb_pkg::*;
#(
   parameter logic [31:0] PERI_ADDR = DEF_PERI_ADDR,
   parameter logic [31:0] PERI_END  = DEF_PERI_END,
   parameter logic [31:0] SMEM_ADDR = DEF_SMEM_ADDR,
   parameter logic [31:0] SMEM_SIZE = DEF_SMEM_SIZE,
   parameter logic [31:0] DMEM_ADDR = DEF_DMEM_ADDR,
   parameter logic [31:0] DMEM_SIZE = DEF_DMEM_SIZE,
   parameter logic [31:0] MMIO_ADDR = DEF_MMIO_ADDR
) (
   input  logic [31:0] addr,
   output dest_e       dest
);

   // 33-bit arithmetic so a region ending at the top of the space does not wrap to zero.
   function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                      input logic [31:0] size);
      logic [32:0] a_x, lo_x, hi_x;
      a_x  = {1'b0, a};
      lo_x = {1'b0, base};
      hi_x = {1'b0, base} + {1'b0, size};
      return (a_x >= lo_x) && (a_x < hi_x);
   endfunction

   always_comb begin
      if ((addr >= PERI_ADDR) && (addr < PERI_END)) begin
         dest = DestPeri;
      end else if (in_region(addr, SMEM_ADDR, SMEM_SIZE)) begin
         dest = DestStack;
      end else if (in_region(addr, DMEM_ADDR, DMEM_SIZE)) begin
         dest = DestDmem;
      end else if (in_region(addr, MMIO_ADDR, 32'd16)) begin
         dest = DestMmio;
      end else begin
         dest = DestErr;
      end
   end

endmodule

// File: rtl/tb_core_data_demux.sv
// Data-bus demux between the core data port and three TCDM targets (0=peri, 1=stack,
// 2=dmem), with an internal MMIO window (exit code, console print, cycle counter).
// Ports:
//   data_*          - core-side request/grant/response
//   tgt_*           - target-side request/grant/response; address and write data broadcast
//   exit_*/print_*  - registered pulses and values from MMIO writes
//   protocol_err_o  - sticky flag for a target response nobody was waiting for
// Responses are kept in order by only letting requests to the destination that already
// has transactions outstanding proceed; no reorder buffer is needed.
module tb_core_data_demux
   import redmule_tb_pkg::*;
#(
   parameter logic [31:0] PERI_ADDR = DEF_PERI_ADDR,
   parameter logic [31:0] PERI_END  = DEF_PERI_END,
   parameter logic [31:0] SMEM_ADDR = DEF_SMEM_ADDR,
   parameter logic [31:0] SMEM_SIZE = DEF_SMEM_SIZE,
   parameter logic [31:0] DMEM_ADDR = DEF_DMEM_ADDR,
   parameter logic [31:0] DMEM_SIZE = DEF_DMEM_SIZE,
   parameter logic [31:0] MMIO_ADDR = DEF_MMIO_ADDR,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             data_req_i,
   output logic             data_gnt_o,
   input  logic             data_we_i,
   input  logic [3:0]       data_be_i,
   input  logic [31:0]      data_addr_i,
   input  logic [31:0]      data_wdata_i,
   output logic             data_rvalid_o,
   output logic [31:0]      data_rdata_o,
   output logic             data_err_o,
   output logic [2:0]       tgt_req_o,
   input  logic [2:0]       tgt_gnt_i,
   output logic [31:0]      tgt_add_o,
   output logic             tgt_wen_o,
   output logic [3:0]       tgt_be_o,
   output logic [31:0]      tgt_data_o,
   input  logic [2:0][31:0] tgt_r_data_i,
   input  logic [2:0]       tgt_r_valid_i,
   output logic             exit_valid_o,
   output logic [31:0]      exit_code_o,
   output logic             print_valid_o,
   output logic [7:0]       print_char_o,
   output logic             protocol_err_o
);

   localparam int unsigned     CntW   = $clog2(MAX_OUTST + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTST);

   dest_e           req_dest, cur_q, cur_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_after;
   logic            rsp, stall, issue, local_grant;
   logic            mem_rvalid;
   logic [31:0]     mem_rdata;
   logic [2:0]      expect_mask;
   logic [3:0]      mmio_off;
   logic            exit_wr, print_wr, pipe_err_d;
   logic [31:0]     pipe_rdata_d;

   logic            pipe_valid_q, pipe_err_q;
   logic [31:0]     pipe_rdata_q;
   logic [31:0]     cycle_q, exit_code_q;
   logic            exit_valid_q, print_valid_q, proto_err_q;
   logic [7:0]      print_char_q;

   tb_addr_decoder #(
      .PERI_ADDR (PERI_ADDR),
      .PERI_END  (PERI_END),
      .SMEM_ADDR (SMEM_ADDR),
      .SMEM_SIZE (SMEM_SIZE),
      .DMEM_ADDR (DMEM_ADDR),
      .DMEM_SIZE (DMEM_SIZE),
      .MMIO_ADDR (MMIO_ADDR)
   ) u_decoder (
      .addr (data_addr_i),
      .dest (req_dest)
   );

   // Response side: only the current destination may answer, and only while work is pending.
   always_comb begin
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      expect_mask = '0;
      if (cnt_q != '0) begin
         unique case (cur_q)
            DestPeri: begin
               mem_rvalid     = tgt_r_valid_i[0];
               mem_rdata      = tgt_r_data_i[0];
               expect_mask[0] = 1'b1;
            end
            DestStack: begin
               mem_rvalid     = tgt_r_valid_i[1];
               mem_rdata      = tgt_r_data_i[1];
               expect_mask[1] = 1'b1;
            end
            DestDmem: begin
               mem_rvalid     = tgt_r_valid_i[2];
               mem_rdata      = tgt_r_data_i[2];
               expect_mask[2] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rsp           = mem_rvalid | pipe_valid_q;
   assign data_rvalid_o = rsp;
   assign data_rdata_o  = mem_rvalid ? mem_rdata : (pipe_valid_q ? pipe_rdata_q : 32'h0);
   assign data_err_o    = pipe_valid_q & pipe_err_q;

   // A response retiring this cycle frees its slot for a same-cycle grant.
   assign cnt_after = cnt_q - CntW'(rsp);
   assign stall     = (cnt_after == MaxCnt) || ((cnt_after != '0) && (req_dest != cur_q));
   assign issue     = data_req_i & rst_ni & ~stall;

   always_comb begin
      tgt_req_o  = '0;
      data_gnt_o = 1'b0;
      if (issue) begin
         unique case (req_dest)
            DestPeri: begin
               tgt_req_o[0] = 1'b1;
               data_gnt_o   = tgt_gnt_i[0];
            end
            DestStack: begin
               tgt_req_o[1] = 1'b1;
               data_gnt_o   = tgt_gnt_i[1];
            end
            DestDmem: begin
               tgt_req_o[2] = 1'b1;
               data_gnt_o   = tgt_gnt_i[2];
            end
            DestMmio, DestErr: data_gnt_o = 1'b1;
            default: ;
         endcase
      end
   end

   // Broadcast fields are forced low under reset so every output is quiet.
   assign tgt_add_o  = rst_ni ? data_addr_i  : 32'h0;
   assign tgt_wen_o  = rst_ni ? ~data_we_i   : 1'b0;
   assign tgt_be_o   = rst_ni ? data_be_i    : 4'h0;
   assign tgt_data_o = rst_ni ? data_wdata_i : 32'h0;

   always_comb begin
      cnt_d = cnt_after + CntW'(data_gnt_o);
      if (data_gnt_o) begin
         cur_d = req_dest;
      end else if (cnt_d == '0) begin
         cur_d = DestNone;
      end else begin
         cur_d = cur_q;
      end
   end

   // Internal MMIO/ERR accesses answer from a one-deep pipeline register.
   assign local_grant = data_gnt_o & ~is_mem_dest(req_dest);
   assign mmio_off    = data_addr_i[3:0];

   always_comb begin
      exit_wr      = 1'b0;
      print_wr     = 1'b0;
      pipe_err_d   = 1'b0;
      pipe_rdata_d = '0;
      if (req_dest == DestErr) begin
         pipe_err_d = 1'b1;
      end else if (req_dest == DestMmio) begin
         pipe_err_d = (mmio_off == MMIO_BAD);
         exit_wr    = data_we_i && (mmio_off == MMIO_EXIT);
         print_wr   = data_we_i && (mmio_off == MMIO_PRINT);
         if (!data_we_i && (mmio_off == MMIO_CYCLES)) begin
            pipe_rdata_d = cycle_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q         <= '0;
         cur_q         <= DestNone;
         pipe_valid_q  <= 1'b0;
         pipe_err_q    <= 1'b0;
         pipe_rdata_q  <= '0;
         cycle_q       <= '0;
         exit_valid_q  <= 1'b0;
         exit_code_q   <= '0;
         print_valid_q <= 1'b0;
         print_char_q  <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         cur_q         <= cur_d;
         cycle_q       <= cycle_q + 32'd1;
         pipe_valid_q  <= local_grant;
         exit_valid_q  <= local_grant & exit_wr;
         print_valid_q <= local_grant & print_wr;
         proto_err_q   <= proto_err_q | (|(tgt_r_valid_i & ~expect_mask));
         if (local_grant) begin
            pipe_err_q   <= pipe_err_d;
            pipe_rdata_q <= pipe_rdata_d;
         end
         if (local_grant && exit_wr) begin
            exit_code_q <= data_wdata_i;
         end
         if (local_grant && print_wr) begin
            print_char_q <= data_wdata_i[31:24];
         end
      end
   end

   assign exit_valid_o   = exit_valid_q;
   assign exit_code_o    = exit_code_q;
   assign print_valid_o  = print_valid_q;
   assign print_char_o   = print_char_q;
   assign protocol_err_o = proto_err_q;

endmodule

// File: tb/tb_tb_core_data_demux.sv
// Self-checking bench for tb_core_data_demux: a target responder model with per-target
// latency, a core-side driver, and a response scoreboard filled at grant time.
module tb_tb_core_data_demux;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             data_req_i, data_gnt_o, data_we_i;
   logic [3:0]       data_be_i;
   logic [31:0]      data_addr_i, data_wdata_i;
   logic             data_rvalid_o, data_err_o;
   logic [31:0]      data_rdata_o;
   logic [2:0]       tgt_req_o, tgt_gnt_i, tgt_r_valid_i;
   logic [31:0]      tgt_add_o, tgt_data_o;
   logic             tgt_wen_o;
   logic [3:0]       tgt_be_o;
   logic [2:0][31:0] tgt_r_data_i;
   logic             exit_valid_o, print_valid_o, protocol_err_o;
   logic [31:0]      exit_code_o;
   logic [7:0]       print_char_o;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } pend_t;

   exp_t       sb[$];
   pend_t      pq[3][$];
   int         lat[3];
   logic [2:0] inject;
   int         cyc;
   int         n_checks;
   int         n_errors;

   always #5 clk = ~clk;

   tb_core_data_demux u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .data_req_i     (data_req_i),
      .data_gnt_o     (data_gnt_o),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .tgt_req_o      (tgt_req_o),
      .tgt_gnt_i      (tgt_gnt_i),
      .tgt_add_o      (tgt_add_o),
      .tgt_wen_o      (tgt_wen_o),
      .tgt_be_o       (tgt_be_o),
      .tgt_data_o     (tgt_data_o),
      .tgt_r_data_i   (tgt_r_data_i),
      .tgt_r_valid_i  (tgt_r_valid_i),
      .exit_valid_o   (exit_valid_o),
      .exit_code_o    (exit_code_o),
      .print_valid_o  (print_valid_o),
      .print_char_o   (print_char_o),
      .protocol_err_o (protocol_err_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0011_0010) return 32'hCAFE_BABE;
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
   endfunction

   // Target model: grant always, answer in order after lat[i] cycles.
   initial begin
      pend_t p;
      cyc           = 0;
      tgt_gnt_i     = 3'b111;
      tgt_r_valid_i = '0;
      tgt_r_data_i  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (tgt_req_o[i] && tgt_gnt_i[i]) begin
               p.data = tgt_wen_o ? mem_val(tgt_add_o) : 32'h0;
               p.due  = cyc + lat[i];
               pq[i].push_back(p);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < 3; i++) begin
            tgt_r_valid_i[i] = 1'b0;
            tgt_r_data_i[i]  = '0;
            if (pq[i].size() > 0 && pq[i][0].due <= cyc) begin
               tgt_r_valid_i[i] = 1'b1;
               tgt_r_data_i[i]  = pq[i][0].data;
               void'(pq[i].pop_front());
            end
         end
         tgt_r_valid_i = tgt_r_valid_i | inject;
      end
   end

   // Response monitor: every core-side response must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_ni && data_rvalid_o) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_rdata", data_rdata_o, e.rdata);
            check("rsp_err", {31'd0, data_err_o}, {31'd0, e.err});
         end
      end
   end

   // Drive one request from posedge+1 until granted; pushes the expected response.
   task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit chk_stall,
                        output int waits);
      exp_t e;
      data_req_i   = 1'b1;
      data_addr_i  = addr;
      data_we_i    = we;
      data_wdata_i = wdata;
      data_be_i    = 4'hF;
      waits        = 0;
      forever begin
         @(negedge clk);
         if (data_gnt_o) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
            break;
         end
         if (chk_stall) check("stall_tgt_req", {29'd0, tgt_req_o}, 32'd0);
         waits++;
         if (waits > 30) begin
            check("gnt_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      data_be_i    = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int w;
      n_checks     = 0;
      n_errors     = 0;
      inject       = '0;
      lat          = '{1, 1, 1};
      rst_ni       = 1'b0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
      check("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      check("rst_rdata", data_rdata_o, 32'd0);
      check("rst_err", {31'd0, data_err_o}, 32'd0);
      check("rst_tgt_req", {29'd0, tgt_req_o}, 32'd0);
      check("rst_tgt_wen", {31'd0, tgt_wen_o}, 32'd0);
      check("rst_exit_valid", {31'd0, exit_valid_o}, 32'd0);
      check("rst_exit_code", exit_code_o, 32'd0);
      check("rst_print", {23'd0, print_valid_o, print_char_o}, 32'd0);
      check("rst_proto_err", {31'd0, protocol_err_o}, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Single DMEM read.
      issue(32'h0011_0010, 1'b0, 32'h0, 32'hCAFE_BABE, 1'b0, 1'b0, w);
      check("dmem_gnt_wait", w, 32'd0);
      drain();

      // STACK then PERI; PERI held until the STACK response cycle.
      lat[1] = 3;
      issue(32'h0014_0000, 1'b0, 32'h0, mem_val(32'h0014_0000), 1'b0, 1'b0, w);
      check("stack_gnt_wait", w, 32'd0);
      issue(32'h0000_1000, 1'b0, 32'h0, mem_val(32'h0000_1000), 1'b0, 1'b1, w);
      check("peri_stall_cycles", w, 32'd2);
      drain();

      // MMIO print and exit writes.
      issue(32'h8000_0004, 1'b1, 32'h4800_0000, 32'h0, 1'b0, 1'b0, w);
      check("print_gnt_wait", w, 32'd0);
      check("print_valid", {31'd0, print_valid_o}, 32'd1);
      check("print_char", {24'd0, print_char_o}, 32'h48);
      issue(32'h8000_0000, 1'b1, 32'h0000_002A, 32'h0, 1'b0, 1'b0, w);
      check("print_pulse_end", {31'd0, print_valid_o}, 32'd0);
      check("exit_valid_2a", {31'd0, exit_valid_o}, 32'd1);
      check("exit_code_2a", exit_code_o, 32'h2A);
      issue(32'h8000_0000, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, w);
      check("exit_valid_0", {31'd0, exit_valid_o}, 32'd1);
      check("exit_code_0", exit_code_o, 32'd0);
      @(posedge clk);
      #1;
      check("exit_pulse_end", {31'd0, exit_valid_o}, 32'd0);
      issue(32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, w);
      issue(32'h8000_0008, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, w);
      drain();

      // Unmapped and reserved MMIO accesses.
      issue(32'h9000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, w);
      check("err_gnt_wait", w, 32'd0);
      issue(32'h8000_000C, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, w);
      issue(32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, w);
      drain();

      // Three DMEM reads against a two-deep outstanding limit.
      lat[2] = 4;
      issue(32'h0011_0020, 1'b0, 32'h0, mem_val(32'h0011_0020), 1'b0, 1'b0, w);
      issue(32'h0011_0024, 1'b0, 32'h0, mem_val(32'h0011_0024), 1'b0, 1'b0, w);
      check("dmem_second_wait", w, 32'd0);
      issue(32'h0011_0028, 1'b0, 32'h0, mem_val(32'h0011_0028), 1'b0, 1'b1, w);
      check("dmem_third_wait", w, 32'd2);
      drain();
      check("proto_err_clean", {31'd0, protocol_err_o}, 32'd0);

      // Stray target response while idle.
      @(negedge clk);
      inject = 3'b010;
      @(negedge clk);
      inject = 3'b000;
      @(posedge clk);
      #2;
      check("proto_err_set", {31'd0, protocol_err_o}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("proto_err_sticky", {31'd0, protocol_err_o}, 32'd1);

      // Reset in the middle of a DMEM read.
      issue(32'h0011_0030, 1'b0, 32'h0, mem_val(32'h0011_0030), 1'b0, 1'b0, w);
      #2;
      rst_ni = 1'b0;
      #1;
      sb.delete();
      check("mid_rst_proto_err", {31'd0, protocol_err_o}, 32'd0);
      check("mid_rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      check("mid_rst_exit_code", exit_code_o, 32'd0);
      check("mid_rst_print_char", {24'd0, print_char_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      issue(32'h8000_0008, 1'b0, 32'h0, 32'd5, 1'b0, 1'b0, w);
      drain();
      check("late_rsp_proto_err", {31'd0, protocol_err_o}, 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
